la_input_conditioner: RTL
=========================

Name: la_input_conditioner

Overview:
Front-end stage of the tiny logic analyzer, directly upstream of the pulse-width analysis core. It synchronises the raw asynchronous probe input and rejects glitches shorter than a programmable length. It produces a clean level and single-cycle edge strobes, timestamps every filtered edge, and queues the edge events in a small FIFO. The analysis core drains that FIFO through a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, synchroniser flop count (>=2)
FILT_LEN, 8, consecutive stable cycles required to accept a new level (1..2**FILT_W-1)
FILT_W, 4, filter counter width
TS_W, 16, timestamp counter width
DEPTH, 4, event FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
data_in  in  1  raw asynchronous probe input
clear  in  1  synchronous flush: FIFO, overflow flag, timestamp
level  out  1  filtered, synchronised input level
rise  out  1  one-cycle strobe, first cycle level==1
fall  out  1  one-cycle strobe, first cycle level==0
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head this cycle
evt_pol  out  1  head edge polarity (1=rise)
evt_ts  out  TS_W  head timestamp
overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset (rst low, asynchronous): all flops go to 0. level, rise, fall, evt_valid, evt_pol, evt_ts and overflow are 0, and the FIFO is empty. Reset asserted mid-operation discards queued events immediately.
- Synchroniser: a SYNC_STAGES-deep chain reset to 0 produces sync_out.
- Glitch filter: counter cnt and register level.
  - If sync_out==level: cnt<=0.
  - Otherwise: cnt<=cnt+1. When cnt==FILT_LEN-1: level<=sync_out and cnt<=0.
  - Latency from the first sampling of a new data_in value to level changing is SYNC_STAGES+FILT_LEN cycles.
  - Excursions shorter than FILT_LEN cycles at sync_out are ignored and restart the count.
  - FILT_LEN=1 accepts a change one cycle after sync.
- Edge strobes: rise = level & ~level_q and fall = ~level & level_q, where level_q is level delayed one cycle (reset 0). Each strobe lasts exactly one cycle.
- Timestamp: ts is free-running, +1 per cycle, wraps from all-ones to 0, and is reset to 0 by clear in the following cycle. An event captures the ts value present in its strobe cycle.
- FIFO:
  - Push on rise|fall with {pol=rise, ts}. Pop when evt_valid & evt_ready.
  - evt_valid = not empty. The head stays stable while valid and not ready.
  - Push into an empty FIFO: evt_valid rises the cycle after the strobe (no fall-through).
  - Full & push & no pop: the new event is dropped, overflow<=1, and existing entries are kept.
  - Full & push & pop in the same cycle: both occur, no overflow.
  - Empty & pop cannot occur (valid=0).
  - Ordering is strictly FIFO.
- clear:
  - Synchronous. Next cycle: FIFO empty, overflow=0, ts=0.
  - An edge strobe in the clear cycle is not queued.
  - Filter, synchroniser and level are unaffected.
- overflow is cleared only by clear or rst.

Decomposition:
- Package la_pkg:
  - typedef la_event_t {pol, ts[TS_W-1:0]}
  - default constants LA_TS_W=16, LA_FILT_LEN=8, LA_EVT_DEPTH=4
- Sub-module la_event_fifo (parameterised DEPTH and data width):
  - push/pop, full/empty, drop-on-full with overflow output
  - registered head output
- The conditioner holds the synchroniser, filter, edge logic and timestamp, and instantiates la_event_fifo.

Test Plan:
1. Reset and timestamp: hold rst low with data_in toggling → all outputs 0 and FIFO empty. Release rst → evt_ts unchanged and ts increments by 1 per clk.
2. Glitch rejection: with defaults, data_in high for 5 cycles → level, rise and evt_valid stay 0 and no event is queued.
3. Clean rise: data_in 0→1 held → level rises 10 cycles after the first sampling edge; rise high for 1 cycle; next cycle evt_valid=1, evt_pol=1, evt_ts=ts at strobe. Falling edge → fall strobe and evt_pol=0.
4. Overflow: evt_ready=0 with 5 filtered edges → 4 entries queued and overflow=1. Draining gives events 1..4 in order with increasing ts, and the 5th is lost.
5. Full push+pop: FIFO full, evt_ready=1 in the same cycle as an edge strobe → overflow stays 0 and occupancy stays 4.
6. clear, async reset, wrap:
   - clear with 3 queued → evt_valid=0, overflow=0, ts=0 next cycle.
   - rst pulsed low mid-drain → immediate empty.
   - TS_W=4 build: an event after 17 cycles carries ts=1.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and default sizing for the logic-analyzer front end.
package la_pkg;

    localparam int LA_TS_W      = 16;
    localparam int LA_FILT_LEN  = 8;
    localparam int LA_EVT_DEPTH = 4;

    typedef struct packed {
        logic               pol;
        logic [LA_TS_W-1:0] ts;
    } la_event_t;

endpackage

// File: rtl/la_event_fifo.sv
// Small edge-event FIFO with a registered head, drop-on-full and a sticky overflow flag.
module la_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [W-1:0]  head_reg, head_next;
    logic          overflow_reg;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = count_reg[AW];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Head is forwarded from the write port when the new entry lands at the next read slot.
    always_comb begin
        head_next = head_reg;
        if (do_push && (wr_ptr_reg == rd_ptr_next))
            head_next = wdata;
        else if (count_next != '0)
            head_next = mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            if (push && !do_push)
                overflow_reg <= 1'b1;
        end
    end

    assign valid    = ~empty;
    assign head     = head_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/la_input_conditioner.sv
// Probe front end: synchroniser, glitch filter, edge strobes, timestamping and event queue.
module la_input_conditioner
    import la_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = LA_FILT_LEN,
    parameter int FILT_W      = 4,
    parameter int TS_W        = LA_TS_W,
    parameter int DEPTH       = LA_EVT_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data_in,
    input  logic            clear,
    output logic            level,
    output logic            rise,
    output logic            fall,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic            evt_pol,
    output logic [TS_W-1:0] evt_ts,
    output logic            overflow
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic [FILT_W-1:0]      cnt_reg;
    logic                   level_reg, level_q_reg;
    logic [TS_W-1:0]        ts_reg;
    logic                   push;
    logic [TS_W:0]          head;

    assign sync_out = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            level_q_reg <= 1'b0;
            ts_reg      <= '0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], data_in};
            level_q_reg <= level_reg;
            // Any return to the current level restarts the stability count.
            if (sync_out == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == FILT_W'(FILT_LEN - 1)) begin
                level_reg <= sync_out;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + FILT_W'(1);
            end
            ts_reg <= clear ? '0 : ts_reg + TS_W'(1);
        end
    end

    assign level = level_reg;
    assign rise  = level_reg & ~level_q_reg;
    assign fall  = ~level_reg & level_q_reg;
    assign push  = (rise | fall) & ~clear;

    la_event_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (push),
        .wdata    ({rise, ts_reg}),
        .pop      (evt_ready),
        .valid    (evt_valid),
        .head     (head),
        .overflow (overflow)
    );

    assign evt_pol = head[TS_W];
    assign evt_ts  = head[TS_W-1:0];

endmodule
